// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the ALU issue stage.
//   ALU select codes, RV64I opcode/funct3/funct7 constants, skid-buffer
//   occupancy states and the control payload carried next to the operands.
package alu_issue_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;

  // ALU select codes
  localparam logic [SEL_W-1:0] SEL_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] SEL_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] SEL_SLL  = 4'd2;
  localparam logic [SEL_W-1:0] SEL_SLT  = 4'd3;
  localparam logic [SEL_W-1:0] SEL_SLTU = 4'd4;
  localparam logic [SEL_W-1:0] SEL_XOR  = 4'd5;
  localparam logic [SEL_W-1:0] SEL_SRL  = 4'd6;
  localparam logic [SEL_W-1:0] SEL_SRA  = 4'd7;
  localparam logic [SEL_W-1:0] SEL_OR   = 4'd8;
  localparam logic [SEL_W-1:0] SEL_AND  = 4'd9;
  localparam logic [SEL_W-1:0] SEL_X    = 4'd10;
  localparam logic [SEL_W-1:0] SEL_Y    = 4'd11;

  // Major opcodes
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;

  // funct3 for OP / OP-IMM
  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  // funct3 for BRANCH / JALR / LOAD
  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;
  localparam logic [F3_W-1:0] F3_JALR = 3'b000;
  localparam logic [F3_W-1:0] F3_LD   = 3'b011;
  localparam logic [F3_W-1:0] F3_LWU  = 3'b110;
  localparam logic [F3_W-1:0] F3_LRSV = 3'b111;

  localparam logic [F7_W-1:0] F7_BASE = 7'h00;
  localparam logic [F7_W-1:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             illegal;
  } alu_ctl_t;

  // Register/immediate ALU op from funct3 (base encoding, funct7 = 0)
  function automatic logic [SEL_W-1:0] f3_alu_sel(input logic [F3_W-1:0] f3);
    case (f3)
      F3_ADD:  f3_alu_sel = SEL_ADD;
      F3_SLL:  f3_alu_sel = SEL_SLL;
      F3_SLT:  f3_alu_sel = SEL_SLT;
      F3_SLTU: f3_alu_sel = SEL_SLTU;
      F3_XOR:  f3_alu_sel = SEL_XOR;
      F3_SR:   f3_alu_sel = SEL_SRL;
      F3_OR:   f3_alu_sel = SEL_OR;
      default: f3_alu_sel = SEL_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: combinational RV64I decode to ALU operands.
//   inst/pc/rs1/rs2 -> x_c, y_c, ctl_c (select + illegal).
//   ALU_WORD_EN: also decodes OP-32/OP-IMM-32 and drives word_c.
module alu_issue_dec
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] x_c,
  output logic [XLEN-1:0] y_c,
  output alu_ctl_t        ctl_c
`ifdef ALU_WORD_EN
  ,
  output logic            word_c
`endif
);

  logic [OPC_W-1:0] opc;
  logic [F3_W-1:0]  f3;
  logic [F7_W-1:0]  f7;
  logic [XLEN-1:0]  imm_i;
  logic [XLEN-1:0]  imm_s;
  logic [XLEN-1:0]  imm_u;
  logic [XLEN-1:0]  sh_rs2;
  logic [XLEN-1:0]  sh_imm;
  logic             shimm_ok;
  logic             ill;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  // Sign-extends on RV64; same width on RV32, so no extension there
  assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
  assign sh_rs2 = XLEN'(rs2[SHW-1:0]);
  assign sh_imm = XLEN'(inst[20 +: SHW]);
  // Shift-immediate upper bits: only inst[30] may be set; inst[25] is shamt[5] on RV64 only
  assign shimm_ok = !inst[31] && (inst[29:26] == 4'b0000) && !((XLEN == 32) && inst[25]);

`ifdef ALU_WORD_EN
  logic [XLEN-1:0] sh5_rs2;
  logic [XLEN-1:0] sh5_imm;
  assign sh5_rs2 = XLEN'(rs2[4:0]);
  assign sh5_imm = XLEN'(inst[24:20]);
`endif

  // Operand/select decode; illegal encodings collapse to ADD 0,0 at the end
  always_comb begin
    x_c         = '0;
    y_c         = '0;
    ctl_c.sel   = SEL_ADD;
    ill         = 1'b0;
`ifdef ALU_WORD_EN
    word_c      = 1'b0;
`endif
    case (opc)
      OPC_OP: begin
        x_c = rs1;
        y_c = rs2;
        if (f7 == F7_BASE) begin
          ctl_c.sel = f3_alu_sel(f3);
          if (f3 == F3_SLL || f3 == F3_SR) y_c = sh_rs2;
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          ctl_c.sel = SEL_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SR) begin
          ctl_c.sel = SEL_SRA;
          y_c       = sh_rs2;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        x_c = rs1;
        if (f3 == F3_SLL) begin
          ctl_c.sel = SEL_SLL;
          y_c       = sh_imm;
          ill       = !(shimm_ok && !inst[30]);
        end else if (f3 == F3_SR) begin
          ctl_c.sel = inst[30] ? SEL_SRA : SEL_SRL;
          y_c       = sh_imm;
          ill       = !shimm_ok;
        end else begin
          ctl_c.sel = f3_alu_sel(f3);
          y_c       = imm_i;
        end
      end
      OPC_LUI: begin
        ctl_c.sel = SEL_Y;
        y_c       = imm_u;
      end
      OPC_AUIPC: begin
        x_c = pc;
        y_c = imm_u;
      end
      OPC_JAL: begin
        x_c = pc;
        y_c = XLEN'(4);
      end
      OPC_JALR: begin
        x_c = pc;
        y_c = XLEN'(4);
        ill = (f3 != F3_JALR);
      end
      OPC_LOAD: begin
        x_c = rs1;
        y_c = imm_i;
        ill = (f3 == F3_LRSV) || ((XLEN == 32) && (f3 == F3_LD || f3 == F3_LWU));
      end
      OPC_STORE: begin
        x_c = rs1;
        y_c = imm_s;
        ill = f3[2] || ((XLEN == 32) && (f3 == F3_LD));
      end
      OPC_BRANCH: begin
        x_c = rs1;
        y_c = rs2;
        case (f3)
          F3_BEQ, F3_BNE:   ctl_c.sel = SEL_SUB;
          F3_BLT, F3_BGE:   ctl_c.sel = SEL_SLT;
          F3_BLTU, F3_BGEU: ctl_c.sel = SEL_SLTU;
          default:          ill = 1'b1;
        endcase
      end
`ifdef ALU_WORD_EN
      OPC_OP_32: begin
        x_c    = rs1;
        y_c    = rs2;
        word_c = 1'b1;
        if (f7 == F7_BASE && f3 == F3_ADD) begin
          ctl_c.sel = SEL_ADD;
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          ctl_c.sel = SEL_SUB;
        end else if (f7 == F7_BASE && f3 == F3_SLL) begin
          ctl_c.sel = SEL_SLL;
          y_c       = sh5_rs2;
        end else if (f7 == F7_BASE && f3 == F3_SR) begin
          ctl_c.sel = SEL_SRL;
          y_c       = sh5_rs2;
        end else if (f7 == F7_ALT && f3 == F3_SR) begin
          ctl_c.sel = SEL_SRA;
          y_c       = sh5_rs2;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        x_c    = rs1;
        word_c = 1'b1;
        if (f3 == F3_ADD) begin
          y_c = imm_i;
        end else if (f3 == F3_SLL) begin
          ctl_c.sel = SEL_SLL;
          y_c       = sh5_imm;
          ill       = (f7 != F7_BASE);
        end else if (f3 == F3_SR) begin
          ctl_c.sel = inst[30] ? SEL_SRA : SEL_SRL;
          y_c       = sh5_imm;
          ill       = inst[31] || (inst[29:25] != 5'b00000);
        end else begin
          ill = 1'b1;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
    if (ill) begin
      x_c       = '0;
      y_c       = '0;
      ctl_c.sel = SEL_ADD;
`ifdef ALU_WORD_EN
      word_c    = 1'b0;
`endif
    end
    ctl_c.illegal = ill;
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: execute-stage front end; decodes a bundle and presents registered
//   ALU operands behind a valid/ready handshake with a 2-entry skid buffer.
//   Ports: clk, rst_n (async, active-low), flush; in_valid/in_ready with
//   in_inst/in_pc/in_rs1/in_rs2; out_valid/out_ready with out_x/out_y/
//   out_alusel/out_illegal.
//   ALU_WORD_EN: adds out_word and decodes OP-32/OP-IMM-32.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_x,
  output logic [XLEN-1:0]  out_y,
  output logic [SEL_W-1:0] out_alusel,
  output logic             out_illegal
`ifdef ALU_WORD_EN
  ,
  output logic             out_word
`endif
);

  skid_state_t     state;
  skid_state_t     state_next;
  logic            accept;
  logic            drain;
  logic            load_out_in;
  logic            load_out_skid;
  logic            load_skid;
  logic            in_ready_d;
  logic            out_valid_d;

  logic [XLEN-1:0] dec_x;
  logic [XLEN-1:0] dec_y;
  alu_ctl_t        dec_ctl;
  logic [XLEN-1:0] skid_x;
  logic [XLEN-1:0] skid_y;
  alu_ctl_t        skid_ctl;

`ifdef ALU_WORD_EN
  logic            dec_word;
  logic            skid_word;
`endif

  alu_issue_dec #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_dec (
    .inst   (in_inst),
    .pc     (in_pc),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .x_c    (dec_x),
    .y_c    (dec_y),
    .ctl_c  (dec_ctl)
`ifdef ALU_WORD_EN
    ,
    .word_c (dec_word)
`endif
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // State register; handshake flags registered from the next state.
  // in_ready resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state: occupancy tracking; flush overrides everything
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_next = ST_TWO;
          else if (!accept && drain) state_next = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Outputs: register load enables and next handshake flags
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    in_ready_d    = (state_next != ST_TWO);
    out_valid_d   = (state_next != ST_EMPTY);
    if (!flush) begin
      case (state)
        ST_EMPTY: load_out_in = accept;
        ST_ONE: begin
          load_out_in = accept && drain;
          load_skid   = accept && !drain;
        end
        ST_TWO:   load_out_skid = drain;
        default:  load_out_in = 1'b0;
      endcase
    end
  end

  // Output and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_x       <= '0;
      out_y       <= '0;
      out_alusel  <= SEL_ADD;
      out_illegal <= 1'b0;
      skid_x      <= '0;
      skid_y      <= '0;
      skid_ctl    <= '{sel: SEL_ADD, illegal: 1'b0};
    end else begin
      if (load_skid) begin
        skid_x   <= dec_x;
        skid_y   <= dec_y;
        skid_ctl <= dec_ctl;
      end
      if (load_out_in) begin
        out_x       <= dec_x;
        out_y       <= dec_y;
        out_alusel  <= dec_ctl.sel;
        out_illegal <= dec_ctl.illegal;
      end else if (load_out_skid) begin
        out_x       <= skid_x;
        out_y       <= skid_y;
        out_alusel  <= skid_ctl.sel;
        out_illegal <= skid_ctl.illegal;
      end
    end
  end

`ifdef ALU_WORD_EN
  // Word flag staged alongside the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_word <= 1'b0;
      out_word  <= 1'b0;
    end else begin
      if (load_skid) skid_word <= dec_word;
      if (load_out_in)        out_word <= dec_word;
      else if (load_out_skid) out_word <= skid_word;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized + directed bench for alu_issue (XLEN=64).
//   A queue of expected operand records models the buffer; decode expectations
//   come from an instruction-level reference function.
module tb_alu_issue;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [3:0]  sel;
    logic        ill;
    logic        x_care;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_x;
  logic [63:0] out_y;
  logic [3:0]  out_alusel;
  logic        out_illegal;
`ifdef ALU_WORD_EN
  logic        out_word;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   drained = 0;
  logic last_acc = 1'b0;
  exp_t q[$];
  logic [3:0] f3_sel [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_alusel  (out_alusel),
    .out_illegal (out_illegal)
`ifdef ALU_WORD_EN
    ,
    .out_word    (out_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction-level reference decode (RV64I, word ops disabled)
  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc,
                                   input logic [63:0] rs1, input logic [63:0] rs2);
    exp_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_u;
    op    = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    imm_i = {{52{inst[31]}}, inst[31:20]};
    imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    imm_u = {{32{inst[31]}}, inst[31:12], 12'h000};
    e = '{x: 64'd0, y: 64'd0, sel: 4'd0, ill: 1'b0, x_care: 1'b1};
    case (op)
      7'h33: begin
        e.x = rs1;
        e.y = rs2;
        if (f7 == 7'h00) begin
          e.sel = f3_sel[f3];
          if (f3 == 3'd1 || f3 == 3'd5) e.y = rs2 % 64;
        end else if (f7 == 7'h20 && f3 == 3'd0) e.sel = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) begin
          e.sel = 4'd7;
          e.y   = rs2 % 64;
        end else e.ill = 1'b1;
      end
      7'h13: begin
        e.x = rs1;
        if (f3 == 3'd1) begin
          e.sel = 4'd2;
          e.y   = 64'(inst[25:20]);
          e.ill = (inst[31:26] != 6'h00);
        end else if (f3 == 3'd5) begin
          e.y = 64'(inst[25:20]);
          if (inst[31:26] == 6'h00)      e.sel = 4'd6;
          else if (inst[31:26] == 6'h10) e.sel = 4'd7;
          else                           e.ill = 1'b1;
        end else begin
          e.sel = f3_sel[f3];
          e.y   = imm_i;
        end
      end
      7'h37: begin e.sel = 4'd11; e.y = imm_u; e.x_care = 1'b0; end
      7'h17: begin e.x = pc; e.y = imm_u; end
      7'h6F: begin e.x = pc; e.y = 64'd4; end
      7'h67: begin e.x = pc; e.y = 64'd4; e.ill = (f3 != 3'd0); end
      7'h63: begin
        e.x = rs1;
        e.y = rs2;
        if (f3 <= 3'd1)      e.sel = 4'd1;
        else if (f3 <= 3'd3) e.ill = 1'b1;
        else if (f3 <= 3'd5) e.sel = 4'd3;
        else                 e.sel = 4'd4;
      end
      7'h03: begin e.x = rs1; e.y = imm_i; e.ill = (f3 == 3'd7); end
      7'h23: begin e.x = rs1; e.y = imm_s; e.ill = f3[2]; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.x = 64'd0; e.y = 64'd0; e.sel = 4'd0; e.x_care = 1'b1;
    end
    return e;
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance the model
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                      input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic ordy, input logic fl);
    logic acc;
    logic drn;
    exp_t e;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      if (e.x_care) chk("out_x", out_x, e.x);
      chk("out_y", out_y, e.y);
      chk("out_alusel", 64'(out_alusel), 64'(e.sel));
      chk("out_illegal", 64'(out_illegal), 64'(e.ill));
    end
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    in_rs1    = rs1;
    in_rs2    = rs2;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() != 0);
    last_acc = acc && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (drn) begin
        void'(q.pop_front());
        drained++;
      end
      if (acc) q.push_back(ref_dec(inst, pc, rs1, rs2));
    end
  endtask

  function automatic logic [31:0] mk_i(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd2, op};
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd3, 5'd1, f3, 5'd2, op};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 13);
    case (k)
      0, 1: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: w[31:25] = 7'(($urandom()));
        endcase
      end
      2, 3: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 2) != 0) w[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
      end
      4:  w[6:0] = 7'h37;
      5:  w[6:0] = 7'h17;
      6:  w[6:0] = 7'h6F;
      7: begin
        w[6:0] = 7'h67;
        if ($urandom_range(0, 2) != 0) w[14:12] = 3'd0;
      end
      8:  w[6:0] = 7'h63;
      9:  w[6:0] = 7'h03;
      10: w[6:0] = 7'h23;
      11: w[6:0] = 7'h3B;
      12: w[6:0] = 7'h1B;
      default: w[6:0] = 7'(($urandom()));
    endcase
    return w;
  endfunction

  function automatic logic [63:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 300));
    return {$urandom(), $urandom()};
  endfunction

  localparam logic [63:0] Z = 64'd0;

  initial begin
    int idx;
    logic [31:0] bq [3];
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = Z; in_rs1 = Z; in_rs2 = Z;

    // Reset values
    #12;
    chk("rst_out_valid", 64'(out_valid), Z);
    chk("rst_out_x", out_x, Z);
    chk("rst_out_y", out_y, Z);
    chk("rst_out_alusel", 64'(out_alusel), Z);
    chk("rst_out_illegal", 64'(out_illegal), Z);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // ADDI rs1=5, imm=-3
    step(1'b1, mk_i(7'h13, 3'd0, 12'hFFD), 64'h1000, 64'd5, Z, 1'b1, 1'b0);
    #6;
    chk("addi_x", out_x, 64'd5);
    chk("addi_y", out_y, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("addi_sel", 64'(out_alusel), 64'd0);
    // SRAI shamt=63
    step(1'b1, mk_i(7'h13, 3'd5, 12'h43F), Z, 64'h8000_0000_0000_0000, Z, 1'b1, 1'b0);
    #6;
    chk("srai_y", out_y, 64'd63);
    chk("srai_sel", 64'(out_alusel), 64'd7);
    // SRA rs2=0x141 -> shift amount 1
    step(1'b1, mk_r(7'h33, 3'd5, 7'h20), Z, 64'hF0, 64'h141, 1'b1, 1'b0);
    #6;
    chk("sra_y", out_y, 64'd1);
    chk("sra_sel", 64'(out_alusel), 64'd7);
    // Unknown opcode 0x7F
    step(1'b1, 32'h1234_567F, 64'h40, 64'h55, 64'h66, 1'b1, 1'b0);
    #6;
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_sel", 64'(out_alusel), Z);
    chk("ill_x", out_x, Z);
    chk("ill_y", out_y, Z);
    // LUI 0x80000
    step(1'b1, {20'h80000, 5'd4, 7'h37}, Z, Z, Z, 1'b1, 1'b0);
    #6;
    chk("lui_y", out_y, 64'hFFFF_FFFF_8000_0000);
    chk("lui_sel", 64'(out_alusel), 64'd11);
    step(1'b0, 32'd0, Z, Z, Z, 1'b1, 1'b0);

    // Back-pressure: three bundles while out_ready=0, then release
    bq[0] = mk_i(7'h13, 3'd0, 12'd1);
    bq[1] = mk_i(7'h13, 3'd0, 12'd2);
    bq[2] = mk_i(7'h13, 3'd0, 12'd3);
    drained = 0;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      step(idx < 3, (idx < 3) ? bq[idx] : 32'd0, Z, 64'(100 + idx), Z, c >= 4, 1'b0);
      if (c == 2) begin
        #6;
        chk("bp_ready_low", 64'(in_ready), Z);
      end
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd3);
    chk("bp_drained", 64'(drained), 64'd3);

    // Fill to two entries, then flush with a simultaneous in_valid
    step(1'b1, mk_i(7'h13, 3'd4, 12'h0F0), Z, 64'd7, Z, 1'b0, 1'b0);
    step(1'b1, mk_i(7'h13, 3'd6, 12'h00F), Z, 64'd8, Z, 1'b0, 1'b0);
    step(1'b1, mk_i(7'h13, 3'd7, 12'h0FF), Z, 64'd9, Z, 1'b0, 1'b0);
    step(1'b1, mk_i(7'h13, 3'd0, 12'h001), Z, 64'd10, Z, 1'b0, 1'b1);
    #6;
    chk("flush_out_valid", 64'(out_valid), Z);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) step(1'b0, 32'd0, Z, Z, Z, 1'b1, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), rand_op(), rand_op(), rand_op(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    // Mid-stream asynchronous reset
    step(1'b1, mk_i(7'h13, 3'd0, 12'h123), Z, 64'hABCD, Z, 1'b0, 1'b0);
    step(1'b1, mk_i(7'h13, 3'd0, 12'h456), Z, 64'hBCDE, Z, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), Z);
    chk("arst_out_x", out_x, Z);
    chk("arst_out_y", out_y, Z);
    chk("arst_out_alusel", 64'(out_alusel), Z);
    chk("arst_out_illegal", 64'(out_illegal), Z);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      step($urandom_range(0, 1) != 0, rand_inst(), rand_op(), rand_op(), rand_op(), 1'b1, 1'b0);
    end
    step(1'b0, 32'd0, Z, Z, Z, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
